// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the
//   ID-stage load-use hazard, the ID-stage taken branch and a level handshake
//   with the data cache into per-stage enable / bubble / flush controls. It also
//   provides a start gate, a cache-wait watchdog and saturating perf counters.
//
// Parameters
//   TIMEOUT : max total freeze cycles of one cache access before HALT (>= 2)
//   CNT_W   : width of each performance counter
//
// Ports
//   clk_i          : clock, all state on rising edge
//   rst_i          : asynchronous active-low reset
//   start_i        : leave IDLE (level)
//   hazard_i       : load-use hazard detected in ID
//   branch_taken_i : branch/jump in ID resolved taken
//   mem_access_i   : valid load/store in MEM stage
//   mem_ack_i      : data cache completes current access
//   mem_req_o      : request to data cache
//   pc_write_o     : PC register enable
//   if_id_write_o  : IF/ID enable
//   if_id_flush_o  : IF/ID clear to NOP
//   id_ex_noop_o   : load ID/EX with a bubble
//   stage_write_o  : ID/EX, EX/MEM, MEM/WB enable
//   err_o          : watchdog fired (sticky until reset)
//   freeze_cnt_o   : cycles frozen on the cache
//   bubble_cnt_o   : load-use bubbles inserted
//   flush_cnt_o    : IF/ID flushes issued
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_noop_o,
  output logic             stage_write_o,
  output logic             err_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  localparam int              WAIT_W    = $clog2(TIMEOUT);
  // The RUN miss cycle is the first freeze and is not counted by the wait
  // counter, so the TIMEOUT-th freeze is the MEM_WAIT cycle whose increment
  // lands on TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_err;
  logic              w_freeze;
  logic [CNT_W-1:0]  r_freeze_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  assign w_wait_inc = r_wait_cnt + 1'b1;

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_next_state  = r_state;
    w_freeze      = 1'b0;
    mem_req_o     = 1'b0;
    pc_write_o    = 1'b0;
    if_id_write_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_noop_o  = 1'b0;
    stage_write_o = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = S_RUN;
      end

      S_RUN, S_MEM_WAIT: begin
        // MEM_WAIT keeps the request up even if MEM-stage valid drops.
        mem_req_o = (r_state == S_MEM_WAIT) ? 1'b1 : mem_access_i;

        if (mem_req_o && !mem_ack_i) begin
          // Cache freeze: every enable stays low.
          w_freeze = 1'b1;
          if (r_state == S_RUN)
            w_next_state = S_MEM_WAIT;
          else if (w_wait_inc == WAIT_LAST)
            w_next_state = S_HALT;
        end else begin
          // Cache satisfied (or idle): pipeline advances under ID priorities.
          w_next_state = S_RUN;
          if (hazard_i) begin
            // Branch in ID is ignored; it re-resolves after the bubble.
            id_ex_noop_o  = 1'b1;
            stage_write_o = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            stage_write_o = 1'b1;
            if_id_flush_o = branch_taken_i;
          end
        end
      end

      default: begin
        w_next_state = S_HALT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Counts only while staying in MEM_WAIT; zero on entry and elsewhere.
      if (r_state == S_MEM_WAIT && w_next_state == S_MEM_WAIT)
        r_wait_cnt <= w_wait_inc;
      else
        r_wait_cnt <= '0;
      if (w_next_state == S_HALT)
        r_err <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_freeze_cnt <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_freeze && r_freeze_cnt != CNT_MAX)
        r_freeze_cnt <= r_freeze_cnt + 1'b1;
      if (id_ex_noop_o && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (if_id_flush_o && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign err_o        = r_err;
  assign freeze_cnt_o = r_freeze_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Two instances share the inputs: one with
//   default parameters, one with TIMEOUT=4 / CNT_W=2 for watchdog and counter
//   saturation cases. Inputs change on the falling edge; combinational outputs
//   are sampled 2 ns later, counters after the following rising edge.
//   Output vectors are packed as {mem_req, pc_w, if_id_w, flush, noop, stage_w, err}.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0, hazard_i = 1'b0, branch_taken_i = 1'b0;
  logic mem_access_i = 1'b0, mem_ack_i = 1'b0;

  logic        d_req, d_pc, d_ifid, d_flush, d_noop, d_stage, d_err;
  logic [15:0] d_frz, d_bub, d_fls;
  logic        s_req, s_pc, s_ifid, s_flush, s_noop, s_stage, s_err;
  logic [1:0]  s_frz, s_bub, s_fls;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
    .branch_taken_i(branch_taken_i), .mem_access_i(mem_access_i),
    .mem_ack_i(mem_ack_i), .mem_req_o(d_req), .pc_write_o(d_pc),
    .if_id_write_o(d_ifid), .if_id_flush_o(d_flush), .id_ex_noop_o(d_noop),
    .stage_write_o(d_stage), .err_o(d_err), .freeze_cnt_o(d_frz),
    .bubble_cnt_o(d_bub), .flush_cnt_o(d_fls)
  );

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_small (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
    .branch_taken_i(branch_taken_i), .mem_access_i(mem_access_i),
    .mem_ack_i(mem_ack_i), .mem_req_o(s_req), .pc_write_o(s_pc),
    .if_id_write_o(s_ifid), .if_id_flush_o(s_flush), .id_ex_noop_o(s_noop),
    .stage_write_o(s_stage), .err_o(s_err), .freeze_cnt_o(s_frz),
    .bubble_cnt_o(s_bub), .flush_cnt_o(s_fls)
  );

  wire [6:0] d_vec = {d_req, d_pc, d_ifid, d_flush, d_noop, d_stage, d_err};
  wire [6:0] s_vec = {s_req, s_pc, s_ifid, s_flush, s_noop, s_stage, s_err};

  localparam logic [6:0] V_OFF    = 7'b0000000;
  localparam logic [6:0] V_RUN    = 7'b0110010;
  localparam logic [6:0] V_HIT    = 7'b1110010;
  localparam logic [6:0] V_FREEZE = 7'b1000000;
  localparam logic [6:0] V_BUBBLE = 7'b0000110;
  localparam logic [6:0] V_FLUSH  = 7'b0111010;
  localparam logic [6:0] V_ACKBUB = 7'b1000110;
  localparam logic [6:0] V_HALT   = 7'b0000001;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, let them settle.
  task automatic drive(input logic st, input logic hz, input logic br,
                       input logic acc, input logic ack);
    @(negedge clk_i);
    start_i = st; hazard_i = hz; branch_taken_i = br;
    mem_access_i = acc; mem_ack_i = ack;
    #2;
  endtask

  // Reset both instances and step into RUN; returns settled in RUN, inputs 0.
  task automatic reset_run();
    @(negedge clk_i);
    rst_i = 1'b0;
    {start_i, hazard_i, branch_taken_i, mem_access_i, mem_ack_i} = '0;
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    // ---- Reset state ----
    @(negedge clk_i); #2;
    check("reset_outs", d_vec, V_OFF);
    check("reset_cnts", {d_frz, d_bub}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // ---- Start gate: five idle cycles, then start ----
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 0);
      check("idle_outs", d_vec, V_OFF);
    end
    drive(1, 0, 0, 0, 0);
    check("idle_on_start", d_vec, V_OFF);
    drive(0, 0, 0, 0, 0);
    check("first_run", d_vec, V_RUN);
    check("start_cnts", {d_frz, d_fls}, 32'd0);

    // ---- Cache hit then 3-cycle miss ----
    drive(0, 0, 0, 1, 1);
    check("hit_advance", d_vec, V_HIT);
    drive(0, 0, 0, 1, 0);
    check("miss_run", d_vec, V_FREEZE);
    drive(0, 0, 0, 0, 0);
    check("miss_wait1_req_held", d_vec, V_FREEZE);
    drive(0, 0, 0, 1, 0);
    check("miss_wait2", d_vec, V_FREEZE);
    check("miss_wait2_small", s_vec, V_FREEZE);
    drive(0, 0, 0, 1, 1);
    check("miss_ack", d_vec, V_HIT);
    drive(0, 0, 0, 0, 0);
    check("after_ack_run", d_vec, V_RUN);
    check("freeze_cnt3", d_frz, 32'd3);
    check("freeze_cnt3_small", s_frz, 32'd3);
    drive(0, 0, 0, 1, 0);
    check("back2back_req", d_vec, V_FREEZE);

    // ---- Hazard beats branch, then branch alone ----
    reset_run();
    drive(0, 1, 1, 0, 0);
    check("hazard_and_branch", d_vec, V_BUBBLE);
    drive(0, 0, 1, 0, 0);
    check("branch_only", d_vec, V_FLUSH);
    drive(0, 0, 0, 0, 0);
    check("bubble_cnt1", d_bub, 32'd1);
    check("flush_cnt1", d_fls, 32'd1);

    // ---- Hazard held across a miss: bubble only on the ack cycle ----
    reset_run();
    drive(0, 1, 0, 1, 0);
    check("miss_hazard_run", d_vec, V_FREEZE);
    drive(0, 1, 1, 1, 0);
    check("miss_hazard_wait", d_vec, V_FREEZE);
    drive(0, 1, 0, 1, 1);
    check("ack_hazard_bubble", d_vec, V_ACKBUB);
    drive(0, 0, 0, 0, 0);
    check("ack_hazard_run", d_vec, V_RUN);
    check("ack_hazard_bub", d_bub, 32'd1);
    check("ack_hazard_frz", d_frz, 32'd2);

    // ---- Watchdog: never ack; small halts after 4, default after 64 ----
    reset_run();
    for (int k = 1; k <= 64; k++) begin
      drive(k[0], 0, 1, 1, 0);
      check("wd_default_freeze", d_vec, V_FREEZE);
      if (k <= 4) check("wd_small_freeze", s_vec, V_FREEZE);
      else        check("wd_small_halt", s_vec, V_HALT);
    end
    drive(1, 0, 0, 1, 1);
    check("wd_default_halt", d_vec, V_HALT);
    check("wd_default_frz64", d_frz, 32'd64);
    check("wd_small_frz_sat", s_frz, 32'd3);
    drive(0, 0, 0, 0, 1);
    check("wd_halt_sticky", d_vec, V_HALT);
    check("wd_small_sticky", s_vec, V_HALT);

    // Reset while in HALT clears err and counters.
    rst_i = 1'b0;
    #1;
    check("halt_reset_outs", d_vec, V_OFF);
    check("halt_reset_cnts", {d_frz, s_frz}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // ---- Async reset mid-MEM_WAIT drops mem_req without a clock ----
    reset_run();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("pre_async_wait", d_vec, V_FREEZE);
    rst_i = 1'b0;
    #1;
    check("async_reset_req", d_vec, V_OFF);
    check("async_reset_frz", d_frz, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // ---- Flush counter saturation (CNT_W=2) ----
    reset_run();
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("flush_sat_small", s_fls, 32'd3);
    check("flush_default5", d_fls, 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors + 1);
    $fatal(1);
  end

endmodule
